// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle control FSM and its datapath.
// Carries the optional instret counter when MULTICYCLE_CTRL_INSTRET_EN is defined.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] result_src;
  logic       illegal;
  logic [3:0] state_o;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, imm_src,
           alu_src_a, alu_src_b, alu_control, result_src, illegal, state_o
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    , output instret
`endif
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, imm_src,
           alu_src_a, alu_src_b, alu_control, result_src, illegal, state_o
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    , input instret
`endif
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I subset (lw, sw, R/I ALU, beq, lui).
// Optional retired-instruction counter enabled by MULTICYCLE_CTRL_INSTRET_EN.
module multicycle_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  multicycle_ctrl_if.master bus
);
  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpLui = 7'b0110111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluLui = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StLui      = 4'd10,
    StError    = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic       illegal_q;
  logic       alu_ok;
  logic [2:0] alu_ctl;
  logic       mem_req, mem_write, ir_write, pc_write, reg_write;

  always_comb begin
    alu_ok  = 1'b1;
    alu_ctl = AluAdd;
    case (bus.funct3)
      3'b000:  alu_ctl = (bus.op == OpR && bus.funct7b5) ? AluSub : AluAdd;
      3'b010:  alu_ctl = AluSlt;
      3'b110:  alu_ctl = AluOr;
      3'b111:  alu_ctl = AluAnd;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    mem_req         = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    reg_write       = 1'b0;
    bus.adr_src     = 1'b0;
    bus.imm_src     = 2'b00;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.alu_control = AluAdd;
    bus.result_src  = 2'b00;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write       = 1'b1;
          pc_write       = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
          state_d        = StDecode;
        end
      end
      StDecode: begin
        // Branch target is precomputed here into ALUOut.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = 2'b10;
        case (bus.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecR;
          OpI:        state_d = StExecI;
          OpBeq:      state_d = (bus.funct3 == 3'b000) ? StBeq : StError;
          OpLui:      state_d = StLui;
          default:    state_d = StError;
        endcase
      end
      StMemAdr: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = (bus.op == OpSw) ? 2'b01 : 2'b00;
        state_d       = (bus.op == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.adr_src = 1'b1;
        mem_req     = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        bus.result_src = 2'b01;
        reg_write      = 1'b1;
        state_d        = StFetch;
      end
      StMemWrite: begin
        bus.adr_src = 1'b1;
        mem_req     = 1'b1;
        mem_write   = 1'b1;
        if (bus.mem_ready) state_d = StFetch;
      end
      StExecR: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = alu_ctl;
        state_d         = alu_ok ? StAluWb : StError;
      end
      StExecI: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b01;
        bus.alu_control = alu_ctl;
        state_d         = alu_ok ? StAluWb : StError;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBeq: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = AluSub;
        pc_write        = bus.zero;
        state_d         = StFetch;
      end
      StLui: begin
        bus.alu_src_b   = 2'b01;
        bus.imm_src     = 2'b11;
        bus.alu_control = AluLui;
        state_d         = StAluWb;
      end
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StError) illegal_q <= 1'b1;
    end
  end

  // Strobes are gated by reset so an in-flight access aborts immediately.
  assign bus.mem_req   = mem_req & rst_n;
  assign bus.mem_write = mem_write & rst_n;
  assign bus.ir_write  = ir_write & rst_n;
  assign bus.pc_write  = pc_write & rst_n;
  assign bus.reg_write = reg_write & rst_n;
  assign bus.illegal   = illegal_q;
  assign bus.state_o   = state_q;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [31:0] instret_q;

  // Every entry into FETCH comes from a retiring state; ERROR never leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (state_d == StFetch && state_q != StFetch) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign bus.instret = instret_q;
`endif
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I subset core (lw, sw, R-type ALU, I-type ALU, beq, lui).
- Sequences a shared-ALU, single-memory datapath.
- Drives imm_src into the immediate sign-extender, plus ALU operand/op selects, register/PC/IR write strobes and a req/ready memory handshake.
- Sits between the instruction register and the datapath.

Parameters:
- none (opcode/funct encodings fixed by the RV32I spec)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- op  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  1=store, valid with mem_req
- adr_src  out  1  0=PC, 1=ALUOut as memory address
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write
- imm_src  out  2  00=I, 01=S, 10=B, 11=U (extender select)
- alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=ImmOp, 10=const 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 100 lui (result=ImmOp<<12)
- result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result direct
- illegal  out  1  sticky unsupported-instruction flag
- state_o  out  4  current state encoding (debug)

Behaviour:
- States/encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, LUI=10, ERROR=11.
- Reset (rst_n low, async): state=FETCH, illegal=0.
- While rst_n is low, pc_write, ir_write, reg_write, mem_req and mem_write are forced 0.
- All other outputs default to 0 in every state unless listed below.
- FETCH:
  - adr_src=0, mem_req=1.
  - Hold until mem_ready.
  - In the mem_ready cycle: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, alu_control=add, result_src=10; go to DECODE.
- DECODE:
  - alu_src_a=01, alu_src_b=01, imm_src=10, add (branch target into ALUOut).
  - Dispatch: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 0110111 -> LUI, other -> ERROR.
- MEMADR: alu_src_a=10, alu_src_b=01, add, imm_src=00 (lw) or 01 (sw); go to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: adr_src=1, mem_req=1; hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1; go to FETCH.
- MEMWRITE: adr_src=1, mem_req=1, mem_write=1; hold until mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_control decoded from funct3; go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=00, alu_control decoded from funct3; go to ALUWB.
- ALU decode from funct3:
  - 000 -> add; sub only when op=0110011 and funct7b5=1.
  - 010 -> slt, 110 -> or, 111 -> and.
  - Any other funct3 -> ERROR instead of ALUWB.
- ALUWB: result_src=00, reg_write=1; go to FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero; go to FETCH.
  - funct3 other than 000 -> ERROR from DECODE.
- LUI: alu_src_b=01, imm_src=11, alu_control=100; go to ALUWB.
- ERROR:
  - illegal set to 1; all strobes 0.
  - State held until reset.
- Memory handshake:
  - mem_req and the address/write selects are held stable until the cycle with mem_ready=1.
  - mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
  - mem_ready=1 on the first request cycle gives zero wait states.
- Reset asserted mid-access: mem_req drops immediately (async). On release, the FSM restarts at FETCH and the aborted access is not resumed.
- Instruction latency with zero wait states:
  - lw 5 cycles; sw, R, I, lui 4 cycles; beq 3 cycles.
  - Each mem wait cycle adds 1.

Optional Feature:
- Macro: MULTICYCLE_CTRL_INSTRET_EN.
- When defined:
  - Adds output instret (32 bits), reset to 0.
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Wraps from 0xFFFFFFFF to 0.
  - Not incremented on ERROR.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then mem_ready=1 every cycle, op=0110011, funct3=000, funct7b5=1 -> state sequence 0,1,6,8,0; alu_control=001 in EXECR; reg_write=1 exactly in ALUWB.
- lw (op=0000011) with mem_ready low 3 cycles in MEMREAD -> state stays 3 for 4 cycles with mem_req=1, adr_src=1; imm_src=00 in MEMADR; then MEMWB with result_src=01.
- sw (op=0100011) -> imm_src=01 in MEMADR; MEMWRITE drives mem_write=1; reg_write never 1; returns to FETCH.
- beq twice, zero=1 then zero=0 -> pc_write=1 in BEQ only for zero=1; imm_src=10 in DECODE.
- lui (op=0110111) -> imm_src=11, alu_control=100 in LUI state; op=1111111 -> ERROR, illegal=1 held 20 cycles, all strobes 0.
- rst_n pulsed low during MEMREAD wait -> mem_req=0 same cycle; after release state=0; with MULTICYCLE_CTRL_INSTRET_EN, instret=0 and equals 3 after three retired R-type instructions.
